// File: rtl/piso_spi_pkg.sv
// Shared definitions for the acoustics front-end serial link (PISO transmit / SIPO receive).
// Holds the transmit FSM state encoding and the default link geometry.
package piso_spi_pkg;

   localparam int DEF_DATA_W      = 12;
   localparam int DEF_CLK_DIV     = 2;
   localparam int DEF_LEAD_CYCLES = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ASSERT = 3'd1,
      LEAD   = 3'd2,
      SHIFT  = 3'd3,
      TAIL   = 3'd4,
      DONE   = 3'd5
   } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock generator: half-period counter, registered sclk and rise/fall strobes.
// Strobes are asserted in the cycle before sclk changes, so the FSM can act in step with the edge.
module spi_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_b,
   input  logic en_i,
   input  logic clr_i,
   output logic sclk_o,
   output logic tick_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int             HPW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [HPW-1:0] HP_LAST = HPW'(CLK_DIV - 1);

   logic [HPW-1:0] hp_cnt_q, hp_cnt_d;
   logic           sclk_q, sclk_d;
   logic           tick;

   assign tick = en_i && (hp_cnt_q == HP_LAST);

   // Clear wins over a coincident tick so the frame can end with sclk held low.
   always_comb begin
      hp_cnt_d = hp_cnt_q;
      sclk_d   = sclk_q;
      if (clr_i) begin
         hp_cnt_d = '0;
         sclk_d   = 1'b0;
      end else if (tick) begin
         hp_cnt_d = '0;
         sclk_d   = ~sclk_q;
      end else if (en_i) begin
         hp_cnt_d = hp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         hp_cnt_q <= '0;
         sclk_q   <= 1'b0;
      end else begin
         hp_cnt_q <= hp_cnt_d;
         sclk_q   <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign tick_o = tick;
   assign rise_o = tick & ~sclk_q;
   assign fall_o = tick & sclk_q;

endmodule

// File: rtl/piso_spi_tx.sv
// Parallel-in / serial-out SPI transmitter: one word per valid/ready handshake, framed by cs_n,
// LEAD_CYCLES dummy clocks then MSB-first data; sdo changes on falling sclk edges.
module piso_spi_tx
   import piso_spi_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int LEAD_CYCLES = DEF_LEAD_CYCLES
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              cs_n,
   output logic              sclk,
   output logic              sdo,
   output logic              tx_busy,
   output logic              tx_done,
   output state_e            state_dbg
);

   // Handshake: a word transfers on the posedge where tx_valid & tx_ready are both high;
   // tx_ready is high only in IDLE, so offers made while a frame is in flight are dropped.

   localparam int             R         = LEAD_CYCLES + DATA_W;
   localparam int             RCW       = $clog2(R + 1);
   localparam logic [RCW-1:0] R_LAST    = RCW'(R);
   localparam logic [RCW-1:0] LEAD_LAST = RCW'(LEAD_CYCLES);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [RCW-1:0]      rcnt_q, rcnt_d;
   logic                cs_n_q, cs_n_d;
   logic                sdo_q, sdo_d;
   logic                done_q, done_d;
   logic                gen_en, gen_clr;
   logic                tick, rise, fall;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk    (clk),
      .reset_b(reset_b),
      .en_i   (gen_en),
      .clr_i  (gen_clr),
      .sclk_o (sclk),
      .tick_o (tick),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      rcnt_d  = rcnt_q;
      cs_n_d  = cs_n_q;
      sdo_d   = sdo_q;
      done_d  = 1'b0;
      gen_en  = 1'b0;
      gen_clr = 1'b0;
      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sdo_d  = 1'b0;
            if (tx_valid) begin
               shreg_d = tx_data;
               rcnt_d  = '0;
               cs_n_d  = 1'b0;
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            gen_en = 1'b1;
            if (rise) begin
               rcnt_d = rcnt_q + 1'b1;
               if (LEAD_CYCLES > 0) begin
                  state_d = LEAD;
               end else begin
                  sdo_d   = shreg_q[DATA_W-1];
                  state_d = SHIFT;
               end
            end
         end
         LEAD: begin
            gen_en = 1'b1;
            if (rise) begin
               rcnt_d = rcnt_q + 1'b1;
            end else if (fall && rcnt_q == LEAD_LAST) begin
               sdo_d   = shreg_q[DATA_W-1];
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            gen_en = 1'b1;
            if (rise) begin
               rcnt_d = rcnt_q + 1'b1;
            end else if (fall) begin
               // The last bit stays on sdo through TAIL.
               if (rcnt_q == R_LAST) begin
                  state_d = TAIL;
               end else begin
                  shreg_d = shreg_q << 1;
                  sdo_d   = shreg_d[DATA_W-1];
               end
            end
         end
         TAIL: begin
            gen_en = 1'b1;
            if (tick) begin
               gen_clr = 1'b1;
               cs_n_d  = 1'b1;
               sdo_d   = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= IDLE;
         shreg_q <= '0;
         rcnt_q  <= '0;
         cs_n_q  <= 1'b1;
         sdo_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         rcnt_q  <= rcnt_d;
         cs_n_q  <= cs_n_d;
         sdo_q   <= sdo_d;
         done_q  <= done_d;
      end
   end

   assign tx_ready  = (state_q == IDLE);
   assign tx_busy   = (state_q != IDLE);
   assign cs_n      = cs_n_q;
   assign sdo       = sdo_q;
   assign tx_done   = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_piso_spi_tx.sv
// Directed bench for piso_spi_tx: default geometry instance (dut_a) plus an 8-bit,
// CLK_DIV=1, no-lead instance (dut_b). Cycle k means the cycle after clk edge k of the frame.
module tb_piso_spi_tx;
   import piso_spi_pkg::*;

   logic        clk;
   logic        reset_b;

   logic [11:0] tx_data_a;
   logic        tx_valid_a, tx_ready_a, cs_n_a, sclk_a, sdo_a, tx_busy_a, tx_done_a;
   state_e      state_a;

   logic [7:0]  tx_data_b;
   logic        tx_valid_b, tx_ready_b, cs_n_b, sclk_b, sdo_b, tx_busy_b, tx_done_b;
   state_e      state_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   piso_spi_tx dut_a (
      .clk(clk), .reset_b(reset_b), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
      .tx_ready(tx_ready_a), .cs_n(cs_n_a), .sclk(sclk_a), .sdo(sdo_a),
      .tx_busy(tx_busy_a), .tx_done(tx_done_a), .state_dbg(state_a)
   );

   piso_spi_tx #(.DATA_W(8), .CLK_DIV(1), .LEAD_CYCLES(0)) dut_b (
      .clk(clk), .reset_b(reset_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b), .cs_n(cs_n_b), .sclk(sclk_b), .sdo(sdo_b),
      .tx_busy(tx_busy_b), .tx_done(tx_done_b), .state_dbg(state_b)
   );

   int          vectors, miscompares, cyc;
   int          a_low, a_rises, a_done, a_done_cyc, a_ready_cyc, a_hi_run, a_gap;
   logic [15:0] a_bits;
   logic        a_prev;
   int          b_low, b_rises, b_done, b_done_cyc, b_ready_cyc;
   logic [15:0] b_bits;
   logic        b_prev, b_first;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0;
      a_low = 0; a_rises = 0; a_done = 0; a_done_cyc = 0; a_ready_cyc = 0;
      a_hi_run = 0; a_gap = 0; a_bits = '0; a_prev = sclk_a;
      b_low = 0; b_rises = 0; b_done = 0; b_done_cyc = 0; b_ready_cyc = 0;
      b_bits = '0; b_prev = sclk_b; b_first = 1'b0;
   endtask

   // One clock cycle: outputs sampled on the falling clk edge.
   task automatic sample();
      @(negedge clk);
      cyc++;
      if (!cs_n_a) begin
         a_low++;
         if (a_hi_run > 0) a_gap = a_hi_run;
         a_hi_run = 0;
      end else begin
         a_hi_run++;
      end
      if (sclk_a && !a_prev) begin
         a_rises++;
         a_bits = {a_bits[14:0], sdo_a};
      end
      a_prev = sclk_a;
      if (tx_done_a) begin a_done++; a_done_cyc = cyc; end
      if (tx_ready_a && a_ready_cyc == 0) a_ready_cyc = cyc;

      if (!cs_n_b) b_low++;
      if (sclk_b && !b_prev) begin
         b_rises++;
         b_bits = {b_bits[14:0], sdo_b};
         if (b_rises == 1) b_first = sdo_b;
      end
      b_prev = sclk_b;
      if (tx_done_b) begin b_done++; b_done_cyc = cyc; end
      if (tx_ready_b && b_ready_cyc == 0) b_ready_cyc = cyc;
   endtask

   task automatic start_a(input logic [11:0] d);
      tx_data_a  = d;
      tx_valid_a = 1'b1;
      clear_stats();
   endtask

   task automatic check_frame_a(input string tag, input logic [14:0] bits);
      check({tag, "_rises"},    32'(a_rises), 32'd15);
      check({tag, "_bits"},     32'(a_bits[14:0]), 32'(bits));
      check({tag, "_cs_low"},   32'(a_low), 32'd62);
      check({tag, "_done_cnt"}, 32'(a_done), 32'd1);
      check({tag, "_done_cyc"}, 32'(a_done_cyc), 32'd63);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      reset_b = 1'b0;
      tx_data_a = '0; tx_valid_a = 1'b0;
      tx_data_b = '0; tx_valid_b = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      reset_b = 1'b1;

      // Idle after reset: {cs_n,sclk,sdo,ready,busy,done} = 100100 on both instances.
      for (int i = 0; i < 20; i++) begin
         sample();
         check("idle", 32'({cs_n_a, sclk_a, sdo_a, tx_ready_a, tx_busy_a, tx_done_a,
                            cs_n_b, sclk_b, sdo_b, tx_ready_b, tx_busy_b, tx_done_b}),
               32'(12'b100100_100100));
      end
      check("idle_state_a", 32'(state_a), 32'(IDLE));
      check("idle_state_b", 32'(state_b), 32'(IDLE));

      // Default frame, 12'hA5C: 3 lead zeros then 1010_0101_1100.
      start_a(12'hA5C);
      sample();
      check("a5c_busy", 32'({tx_busy_a, tx_ready_a, cs_n_a}), 32'(3'b100));
      tx_valid_a = 1'b0;
      repeat (69) sample();
      check_frame_a("a5c", 15'h0A5C);
      check("a5c_ready_cyc", 32'(a_ready_cyc), 32'd64);

      // Back-to-back with tx_valid held; data changes to 12'h001 during frame 1.
      start_a(12'hFFF);
      for (int i = 0; i < 130; i++) begin
         sample();
         if (cyc == 1) tx_data_a = 12'h001;
         if (cyc == 63) begin
            check("b2b_f1_bits", 32'(a_bits[14:0]), 32'h0FFF);
            check("b2b_f1_rises", 32'(a_rises), 32'd15);
         end
         if (cyc == 65) tx_valid_a = 1'b0;
      end
      check("b2b_rises", 32'(a_rises), 32'd30);
      check("b2b_f2_bits", 32'(a_bits[14:0]), 32'h0001);
      check("b2b_done_cnt", 32'(a_done), 32'd2);
      check("b2b_done_cyc", 32'(a_done_cyc), 32'd127);
      check("b2b_gap", 32'(a_gap), 32'd2);
      check("b2b_cs_low", 32'(a_low), 32'd124);

      // 8-bit, CLK_DIV=1, no lead: 8'h81, MSB on sdo at the first rising edge.
      tx_data_b  = 8'h81;
      tx_valid_b = 1'b1;
      clear_stats();
      sample();
      tx_valid_b = 1'b0;
      repeat (24) sample();
      check("b81_first", 32'(b_first), 32'd1);
      check("b81_rises", 32'(b_rises), 32'd8);
      check("b81_bits", 32'(b_bits[7:0]), 32'h81);
      check("b81_cs_low", 32'(b_low), 32'd17);
      check("b81_done_cnt", 32'(b_done), 32'd1);
      check("b81_done_cyc", 32'(b_done_cyc), 32'd18);
      check("b81_ready_cyc", 32'(b_ready_cyc), 32'd19);

      // Reset at cycle 30 of a default frame: outputs drop to reset values at once, no tx_done.
      start_a(12'hA5C);
      sample();
      tx_valid_a = 1'b0;
      repeat (29) sample();
      reset_b = 1'b0;
      #1;
      check("rst_outputs", 32'({cs_n_a, sclk_a, sdo_a, tx_ready_a, tx_busy_a, tx_done_a}),
            32'(6'b100100));
      check("rst_state", 32'(state_a), 32'(IDLE));
      repeat (2) sample();
      reset_b = 1'b1;
      repeat (40) sample();
      check("rst_no_done", 32'(a_done), 32'd0);
      start_a(12'hA5C);
      sample();
      tx_valid_a = 1'b0;
      repeat (69) sample();
      check_frame_a("post_rst", 15'h0A5C);

      // tx_valid pulsed mid-frame with other data: ignored, no second frame.
      start_a(12'hA5C);
      sample();
      tx_valid_a = 1'b0;
      for (int i = 0; i < 79; i++) begin
         sample();
         if (cyc == 20) begin
            tx_valid_a = 1'b1;
            tx_data_a  = 12'h3C3;
         end
         if (cyc == 22) tx_valid_a = 1'b0;
      end
      check_frame_a("busy_pulse", 15'h0A5C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
